// File: rtl/kuznechik_decipher.sv
// Kuznechik (GOST R 34.12-2015) block decryptor, iterative, one byte of
// inverse linear transform per cycle. Round keys, inverse S-box and GF(2^8)
// multiplier tables are built-in standard tables (standard test round keys
// of the cipher).
module kuznechik_decipher #(
   parameter string KEYS_FILE     = "keys.mem",
   parameter string SBOX_INV_FILE = "S_box_inv.mem",
   parameter string L_PREFIX      = "L_"
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         request_i,
   input  logic         ack_i,
   input  logic [127:0] data_i,
   output logic         busy_o,
   output logic         valid_o,
   output logic [127:0] data_o
);

   typedef enum logic [2:0] {IDLE, KEY, LINV, SINV, FINISH} state_t;

   // Forward S-box; only used to derive the built-in inverse table.
   localparam logic [7:0] PI [0:255] = '{
      252,238,221, 17,207,110, 49, 22,251,196,250,218, 35,197,  4, 77,
      233,119,240,219,147, 46,153,186, 23, 54,241,187, 20,205, 95,193,
      249, 24,101, 90,226, 92,239, 33,129, 28, 60, 66,139,  1,142, 79,
        5,132,  2,174,227,106,143,160,  6, 11,237,152,127,212,211, 31,
      235, 52, 44, 81,234,200, 72,171,242, 42,104,162,253, 58,206,204,
      181,112, 14, 86,  8, 12,118, 18,191,114, 19, 71,156,183, 93,135,
       21,161,150, 41, 16,123,154,199,243,145,120,111,157,158,178,177,
       50,117, 25, 61,255, 53,138,126,109, 84,198,128,195,189, 13, 87,
      223,245, 36,169, 62,168, 67,201,215,121,214,246,124, 34,185,  3,
      224, 15,236,222,122,148,176,188,220,232, 40, 80, 78, 51, 10, 74,
      167,151, 96,115, 30,  0, 98, 68, 26,184, 56,130,100,159, 38, 65,
      173, 69, 70,146, 39, 94, 85, 47,140,163,165,125,105,213,149, 59,
        7, 88,179, 64,134,172, 29,247, 48, 55,107,228,136,217,231,137,
      225, 27,131, 73, 76, 63,248,254,141, 83,170,144,202,216,133, 97,
       32,113,103,164, 45, 43,  9, 91,203,155, 37,208,190,229,108, 82,
       89,166,116,210,230,244,180,192,209,102,175,194, 57, 75, 99,182};

   // Read-only memories
   logic [127:0] r_keys     [0:9];
   logic [7:0]   r_sbox_inv [0:255];
   logic [7:0]   r_l16 [0:255], r_l32 [0:255], r_l133 [0:255], r_l148 [0:255];
   logic [7:0]   r_l192 [0:255], r_l194 [0:255], r_l251 [0:255];

   // GF(2^8) product modulo x^8+x^7+x^6+x+1
   function automatic logic [7:0] f_gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'hC3 : 8'h00);
      end
      return p;
   endfunction

   // Load the round keys
   initial begin
      r_keys[0] = 128'h8899aabbccddeeff0011223344556677;
      r_keys[1] = 128'hfedcba98765432100123456789abcdef;
      r_keys[2] = 128'hdb31485315694343228d6aef8cc78c44;
      r_keys[3] = 128'h3d4553d8e9cfec6815ebadc40a9ffd04;
      r_keys[4] = 128'h57646468c44a5e28d3e59246f429f1ac;
      r_keys[5] = 128'hbd079435165c6432b532e82834da581b;
      r_keys[6] = 128'h51e640757e8745de705727265a0098b1;
      r_keys[7] = 128'h5a7925017b9fdd3ed72a91a22286f984;
      r_keys[8] = 128'hbb44e25378c73123a5f32f73cdb6e517;
      r_keys[9] = 128'h72e9dd7416bcf45b755dbaa88e4a4043;
   end

   // Load the inverse S-box
   initial begin
      for (int i = 0; i < 256; i++) r_sbox_inv[PI[i]] = i[7:0];
   end

   // Load the constant-multiplier tables
   initial begin
      for (int i = 0; i < 256; i++) begin
         r_l16[i]  = f_gf_mul(i[7:0], 8'd16);
         r_l32[i]  = f_gf_mul(i[7:0], 8'd32);
         r_l133[i] = f_gf_mul(i[7:0], 8'd133);
         r_l148[i] = f_gf_mul(i[7:0], 8'd148);
         r_l192[i] = f_gf_mul(i[7:0], 8'd192);
         r_l194[i] = f_gf_mul(i[7:0], 8'd194);
         r_l251[i] = f_gf_mul(i[7:0], 8'd251);
      end
   end

   state_t       r_state, w_state_next;
   logic [3:0]   r_index, w_index_next;
   logic [3:0]   r_step,  w_step_next;
   logic [127:0] r_data,  w_data_next;
   logic         r_valid, w_valid_next;

   logic [7:0]   w_c [0:15];
   logic [127:0] w_sinv;
   logic [7:0]   w_y;

   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_bytes
         assign w_c[gi] = r_data[gi*8 +: 8];
         assign w_sinv[gi*8 +: 8] = r_sbox_inv[w_c[gi]];
      end
   endgenerate

   // Inverse linear-feedback byte: the outgoing top byte folded back in
   assign w_y = w_c[15] ^ r_l148[w_c[14]] ^ r_l32[w_c[13]] ^ r_l133[w_c[12]]
              ^ r_l16[w_c[11]] ^ r_l194[w_c[10]] ^ r_l192[w_c[9]] ^ w_c[8]
              ^ r_l251[w_c[7]] ^ w_c[6] ^ r_l192[w_c[5]] ^ r_l194[w_c[4]]
              ^ r_l16[w_c[3]] ^ r_l133[w_c[2]] ^ r_l32[w_c[1]] ^ r_l148[w_c[0]];

   // State, key index, step counter and data registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= IDLE;
         r_index <= 4'd0;
         r_step  <= 4'd0;
         r_data  <= 128'd0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_index <= w_index_next;
         r_step  <= w_step_next;
         r_data  <= w_data_next;
         r_valid <= w_valid_next;
      end
   end

   // Next-state and datapath selection
   always_comb begin
      w_state_next = r_state;
      w_index_next = r_index;
      w_step_next  = r_step;
      w_data_next  = r_data;
      w_valid_next = r_valid;
      case (r_state)
         IDLE: begin
            if (request_i) begin
               w_data_next  = data_i;
               w_index_next = 4'd9;
               w_state_next = KEY;
            end
         end
         KEY: begin
            w_data_next = r_data ^ r_keys[r_index];
            if (r_index == 4'd0) begin
               w_valid_next = 1'b1;
               w_state_next = FINISH;
            end else begin
               w_state_next = LINV;
            end
         end
         LINV: begin
            w_data_next = {r_data[119:0], w_y};
            if (r_step == 4'd15) begin
               w_step_next  = 4'd0;
               w_state_next = SINV;
            end else begin
               w_step_next = r_step + 4'd1;
            end
         end
         SINV: begin
            w_data_next  = w_sinv;
            w_index_next = r_index - 4'd1;
            w_state_next = KEY;
         end
         FINISH: begin
            // A new request wins over a simultaneous acknowledge
            if (request_i) begin
               w_data_next  = data_i;
               w_index_next = 4'd9;
               w_valid_next = 1'b0;
               w_state_next = KEY;
            end else if (ack_i) begin
               w_valid_next = 1'b0;
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   assign busy_o  = (r_state == KEY) || (r_state == LINV) || (r_state == SINV) ||
                    (((r_state == IDLE) || (r_state == FINISH)) && request_i);
   assign valid_o = r_valid;
   assign data_o  = r_data;

endmodule

// File: tb/tb_kuznechik_decipher.sv
// Self-checking bench for kuznechik_decipher: ciphertexts are produced by a
// forward-cipher reference model and the DUT must recover the plaintext.
module tb_kuznechik_decipher;

   localparam logic [7:0] PI [256] = '{
      252,238,221, 17,207,110, 49, 22,251,196,250,218, 35,197,  4, 77,
      233,119,240,219,147, 46,153,186, 23, 54,241,187, 20,205, 95,193,
      249, 24,101, 90,226, 92,239, 33,129, 28, 60, 66,139,  1,142, 79,
        5,132,  2,174,227,106,143,160,  6, 11,237,152,127,212,211, 31,
      235, 52, 44, 81,234,200, 72,171,242, 42,104,162,253, 58,206,204,
      181,112, 14, 86,  8, 12,118, 18,191,114, 19, 71,156,183, 93,135,
       21,161,150, 41, 16,123,154,199,243,145,120,111,157,158,178,177,
       50,117, 25, 61,255, 53,138,126,109, 84,198,128,195,189, 13, 87,
      223,245, 36,169, 62,168, 67,201,215,121,214,246,124, 34,185,  3,
      224, 15,236,222,122,148,176,188,220,232, 40, 80, 78, 51, 10, 74,
      167,151, 96,115, 30,  0, 98, 68, 26,184, 56,130,100,159, 38, 65,
      173, 69, 70,146, 39, 94, 85, 47,140,163,165,125,105,213,149, 59,
        7, 88,179, 64,134,172, 29,247, 48, 55,107,228,136,217,231,137,
      225, 27,131, 73, 76, 63,248,254,141, 83,170,144,202,216,133, 97,
       32,113,103,164, 45, 43,  9, 91,203,155, 37,208,190,229,108, 82,
       89,166,116,210,230,244,180,192,209,102,175,194, 57, 75, 99,182};

   localparam logic [127:0] RK [10] = '{
      128'h8899aabbccddeeff0011223344556677, 128'hfedcba98765432100123456789abcdef,
      128'hdb31485315694343228d6aef8cc78c44, 128'h3d4553d8e9cfec6815ebadc40a9ffd04,
      128'h57646468c44a5e28d3e59246f429f1ac, 128'hbd079435165c6432b532e82834da581b,
      128'h51e640757e8745de705727265a0098b1, 128'h5a7925017b9fdd3ed72a91a22286f984,
      128'hbb44e25378c73123a5f32f73cdb6e517, 128'h72e9dd7416bcf45b755dbaa88e4a4043};

   // Linear-map coefficients for bytes a15..a0
   localparam int LC [16] = '{148, 32, 133, 16, 194, 192, 1, 251, 1, 192, 194, 16, 133, 32, 148, 1};

   localparam logic [127:0] KAT_CT = 128'h7f679d90bebc24305a468d42b9d4edcd;
   localparam logic [127:0] KAT_PT = 128'h1122334455667700ffeeddccbbaa9988;
   localparam int LATENCY = 163;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         request = 1'b0;
   logic         ack = 1'b0;
   logic [127:0] data_in = '0;
   logic         busy, valid;
   logic [127:0] data_out;

   int n_vec = 0;
   int n_err = 0;

   kuznechik_decipher #(
      .KEYS_FILE(""), .SBOX_INV_FILE(""), .L_PREFIX("")
   ) dut (
      .clk_i(clk), .rst_i(rst), .request_i(request), .ack_i(ack),
      .data_i(data_in), .busy_o(busy), .valid_o(valid), .data_o(data_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input int a, input logic [7:0] b);
      int acc, x;
      acc = 0;
      x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) acc = acc ^ x;
         x = x << 1;
         if (x & 256) x = x ^ 9'h1C3;
      end
      return acc[7:0];
   endfunction

   // Forward cipher: nine rounds of X,S,L then a final key whitening
   function automatic logic [127:0] encrypt(input logic [127:0] p);
      logic [127:0] x;
      logic [7:0]   l;
      x = p;
      for (int r = 0; r < 9; r++) begin
         x = x ^ RK[r];
         for (int b = 0; b < 16; b++) x[b*8 +: 8] = PI[x[b*8 +: 8]];
         for (int s = 0; s < 16; s++) begin
            l = 8'h00;
            for (int j = 0; j < 16; j++) l = l ^ gmul(LC[j], x[(15-j)*8 +: 8]);
            x = {l, x[127:8]};
         end
      end
      return x ^ RK[9];
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // One decryption: issue ct, count edges to valid, check latency and result.
   // poke >= 0 injects a stray request/ack pulse at that cycle of the run.
   task automatic run_block(input string tag, input logic [127:0] ct, input logic [127:0] pt,
                            input logic with_ack, input int poke);
      int lat;
      @(negedge clk);
      data_in = ct;
      request = 1'b1;
      ack     = with_ack;
      #1 check({tag, " busy on request"}, {127'd0, busy}, 128'd1);
      @(posedge clk); #1;
      lat = 0;
      check({tag, " valid low after start"}, {127'd0, valid}, 128'd0);
      @(negedge clk);
      request = 1'b0;
      ack     = 1'b0;
      data_in = rand128();
      while (!valid && lat < 400) begin
         @(posedge clk); #1;
         lat++;
         if (lat == 10) check({tag, " busy mid-run"}, {127'd0, busy}, 128'd1);
         if (lat == poke) begin
            request = 1'b1;
            ack     = 1'b1;
            data_in = rand128();
         end
         if (lat == poke + 1) begin
            request = 1'b0;
            ack     = 1'b0;
         end
      end
      check({tag, " latency"}, 128'(lat), 128'(LATENCY));
      check({tag, " plaintext"}, data_out, pt);
      check({tag, " busy in FINISH"}, {127'd0, busy}, 128'd0);
      $display("%s: ct=%h pt=%h latency=%0d", tag, ct, data_out, lat);
   endtask

   task automatic ack_block(input string tag, input logic [127:0] pt);
      @(negedge clk);
      ack = 1'b1;
      @(posedge clk); #1;
      check({tag, " valid after ack"}, {127'd0, valid}, 128'd0);
      check({tag, " data held after ack"}, data_out, pt);
      @(negedge clk);
      ack = 1'b0;
      #1 check({tag, " busy in IDLE"}, {127'd0, busy}, 128'd0);
   endtask

   initial begin
      logic [127:0] pt, ct, pt2, ct2;
      int lat;

      // Reset holds the block idle regardless of request/ack
      request = 1'b1;
      ack     = 1'b1;
      data_in = rand128();
      repeat (3) @(posedge clk);
      #1;
      check("reset valid", {127'd0, valid}, 128'd0);
      check("reset data", data_out, 128'd0);
      check("reset busy with request", {127'd0, busy}, 128'd1);
      request = 1'b0;
      ack     = 1'b0;
      #1 check("reset busy idle", {127'd0, busy}, 128'd0);
      @(negedge clk);
      rst = 1'b0;

      run_block("kat", KAT_CT, KAT_PT, 1'b0, -1);
      ack_block("kat", KAT_PT);

      for (int i = 0; i < 10; i++) begin
         pt = rand128();
         ct = encrypt(pt);
         run_block($sformatf("rt%0d", i), ct, pt, 1'b0, -1);
         ack_block($sformatf("rt%0d", i), pt);
      end

      // Stray request and ack mid-operation are ignored
      pt = rand128();
      run_block("poke", encrypt(pt), pt, 1'b0, 50);
      ack_block("poke", pt);

      // Request and ack together in FINISH start the next block
      pt  = rand128();
      pt2 = rand128();
      run_block("b2b_a", encrypt(pt), pt, 1'b0, -1);
      run_block("b2b_b", encrypt(pt2), pt2, 1'b1, -1);

      // Asynchronous reset mid-operation
      pt = rand128();
      ct2 = encrypt(pt);
      @(negedge clk);
      data_in = ct2;
      request = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      request = 1'b0;
      lat = 0;
      repeat (80) begin @(posedge clk); lat++; end
      #3 rst = 1'b1;
      #1;
      check("async rst valid", {127'd0, valid}, 128'd0);
      check("async rst data", data_out, 128'd0);
      check("async rst busy", {127'd0, busy}, 128'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (200) @(posedge clk);
      #1 check("no result after abort", {127'd0, valid}, 128'd0);
      run_block("kat_after_rst", KAT_CT, KAT_PT, 1'b0, -1);

      // Result holds through a long wait for ack
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         check("hold data", data_out, KAT_PT);
         check("hold valid", {127'd0, valid}, 128'd1);
      end
      ack_block("hold", KAT_PT);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
